// File: rtl/tt_check_pkg.sv
// rtl/tt_check_pkg.sv - shared state encoding, depth helper and golden mask for truth_table_checker
package tt_check_pkg;

    typedef enum logic [1:0] {
        TT_IDLE    = 2'd0,
        TT_COLLECT = 2'd1,
        TT_DONE    = 2'd2
    } tt_state_e;

    function automatic int TT_DEPTH(input int n);
        return 1 << n;
    endfunction

    // Product-of-sums reference function, bit i = response for vector i
    localparam logic [15:0] TT_POS_MASK = 16'h7310;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - rebuilds a 2**N_IN truth table from sampled responses and checks it against a golden mask
// Optional idle-abort enabled by defining TT_CHECK_TIMEOUT_EN.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                         N_IN     = 4,
    parameter logic [(1 << N_IN)-1:0]     EXPECTED = TT_POS_MASK,
    parameter int                         ERR_W    = 5,
    parameter int                         TIMEOUT  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [N_IN-1:0]               in_vec,
    input  logic                          in_resp,
    output logic                          in_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_W-1:0]              err_count,
    output logic [N_IN-1:0]               first_err_vec,
    output logic                          inconsistent,
    output logic [TT_DEPTH(N_IN)-1:0]     seen,
    output logic [TT_DEPTH(N_IN)-1:0]     captured,
    output logic                          timeout
);

    localparam int DEPTH = TT_DEPTH(N_IN);

    tt_state_e          state;
    logic               accept;
    logic               is_new;
    logic               mismatch;
    logic               err_inc;
    logic               complete;
    logic               idle_expired;
    logic [DEPTH-1:0]   seen_next;

    assign in_ready  = (state == TT_COLLECT);
    assign busy      = (state == TT_COLLECT);
    assign done      = (state == TT_DONE);
    assign pass      = done & (err_count == '0) & ~inconsistent & ~timeout;

    // start has priority: a sample presented alongside start is dropped
    assign accept    = in_valid & in_ready & ~start;
    assign is_new    = ~seen[in_vec];
    assign mismatch  = (in_resp != EXPECTED[in_vec]);
    assign err_inc   = accept & is_new & mismatch;
    assign seen_next = seen | (DEPTH'(1) << in_vec);
    assign complete  = accept & (&seen_next);

    sat_counter #(.WIDTH(ERR_W)) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (err_inc),
        .q     (err_count)
    );

`ifdef TT_CHECK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_count;

    sat_counter #(.WIDTH(IDLE_W)) u_idle_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start | accept | (state != TT_COLLECT)),
        .inc   (state == TT_COLLECT),
        .q     (idle_count)
    );

    // idle_count holds the idle cycles already elapsed, so TIMEOUT-1 marks the last allowed one
    assign idle_expired = (state == TT_COLLECT) & ~accept & ~start
                        & (idle_count == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (start) begin
            timeout <= 1'b0;
        end else if (idle_expired) begin
            timeout <= 1'b1;
        end
    end
`else
    assign idle_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= TT_IDLE;
            seen          <= '0;
            captured      <= '0;
            first_err_vec <= '0;
            inconsistent  <= 1'b0;
        end else if (start) begin
            state         <= TT_COLLECT;
            seen          <= '0;
            captured      <= '0;
            first_err_vec <= '0;
            inconsistent  <= 1'b0;
        end else if (state == TT_COLLECT) begin
            if (accept) begin
                if (is_new) begin
                    seen[in_vec]     <= 1'b1;
                    captured[in_vec] <= in_resp;
                    // err_count never wraps, so zero means no mismatch yet
                    if (mismatch && (err_count == '0)) begin
                        first_err_vec <= in_vec;
                    end
                end else if (in_resp != captured[in_vec]) begin
                    inconsistent <= 1'b1;
                end
            end
            if (complete || idle_expired) begin
                state <= TT_DONE;
            end
        end
    end

endmodule
